uart_rx_os: RTL
===============

# uart_rx_os

Oversampling RS232 serial receiver that deserialises `rx_i` into DATA_W-bit words and pushes each one into the UART RX FIFO/buffer through a write-ready handshake. It sits between the FPGA serial input pin and the rbus UART RX register stage. It replaces phase-accumulator bit timing with an integer divider, OSR ticks per bit and 3-sample majority voting. Line and overrun faults go to debug pulses.

## Interface
- DATA_W, 8, data bits per frame
- SYNC_W, 2, input synchroniser depth (≥2)
- CLK_HZ, 160000000, core clock frequency
- BAUD_HZ, 115200, line baud rate
- OSR, 16, oversample ticks per bit (even, ≥4)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active high
- rx_i  in  1  serial data (asynchronous)
- wr_rdy_i  in  1  downstream FIFO can accept
- wr_o  out  1  one-cycle write strobe
- data_o  out  DATA_W  received word, LSB = first bit on line
- line_err_o  out  1  one-cycle pulse: false start, bad stop, or bad parity
- wr_err_o  out  1  one-cycle pulse: valid word dropped because wr_rdy_i was low

## Operation
- Synchroniser: SYNC_W flops, all preset to 1 (idle line). All logic uses the synchronised bit `rx_s`.
- Divider: DIV = max(1, round(CLK_HZ/(BAUD_HZ·OSR))). Counter width max(1,$clog2(DIV)). Emits a `tick` every DIV clocks. Counter is reloaded to 0 on start detection so the tick phase is frame-aligned.
- Tick counter: 0..OSR-1 within each bit. Wraps to 0 and advances the bit index.
- Sampling: samples are taken at tick counts OSR/2-1, OSR/2 and OSR/2+1. The bit value is the majority (2 of 3). The decision is made on tick OSR/2+1.
- States:
  - IDLE: `rx_s`=0 → START, with divider and tick counter cleared.
  - START: on decision, bit=1 → pulse line_err_o, go to IDLE. Bit=0 → DATA, bit index 0.
  - DATA: shift the decision into a shift register at MSB, shift right. After DATA_W bits → PAR if parity is compiled in, else STOP.
  - PAR: decision ≠ even parity of the data → set the error flag. Go to STOP.
  - STOP: on decision:
    - bit=0 → pulse line_err_o, drop the word, go to BRK.
    - parity flag set → pulse line_err_o, drop the word, go to IDLE.
    - otherwise, if wr_rdy_i=1 → pulse wr_o and load data_o. If wr_rdy_i=0 → pulse wr_err_o.
    - go to IDLE immediately, without waiting for the end of the stop bit, to allow resync.
  - BRK: stay until `rx_s`=1 for one full tick, then go to IDLE.
- data_o holds its last written value between writes.
- wr_o, line_err_o and wr_err_o are mutually exclusive in any cycle.

## Timing
- Reset: state IDLE; wr_o=0, line_err_o=0, wr_err_o=0, data_o=0; synchroniser=all 1s; counters=0.
- Reset mid-frame abandons the frame silently, with no error pulse.
- wr_o, wr_err_o and line_err_o are registered. Each asserts for exactly 1 clk, on the cycle after the clock containing the deciding tick.
- wr_rdy_i is sampled only on the stop-bit decision clock.
- End-to-end latency from an rx_i fall to wr_o = SYNC_W + 1 + DIV·(OSR·(DATA_W+1) + OSR/2 + 2) clks, ±DIV, with no parity. Add DIV·OSR with parity.
- Back-to-back frames with a single stop bit are received without loss.

## Configuration
- UART_RX_PARITY_EN defined: frame is DATA_W,E,1. The PAR state exists and parity mismatch pulses line_err_o.
- Undefined: frame is DATA_W,n,1, with no PAR state or parity logic.

## Structure
- Shared package `hive_params`: UART_W, UART_BAUD_HZ, CORE_HZ, a new UART_RX_OSR constant, and the receiver state enum typedef.
- One sub-module: `uart_os_tick`, the divider plus tick counter with sync clear. It outputs `tick`, `tick_cnt` and `bit_end`.

## Test plan
Use CLK_HZ=32000000, BAUD_HZ=1000000, OSR=16, so DIV=2 and a bit is 32 clks.
- Frame 0xA5 with wr_rdy_i=1 → one wr_o pulse, data_o=0xA5, at the specified latency ±2 clks; no error pulses.
- 8-clk low glitch on an idle line → line_err_o pulses once; no wr_o; the next 0x3C frame is received correctly.
- Frame 0x3C with stop bit=0, line then held low for 100 clks → one line_err_o pulse; no wr_o; no further pulses until the line returns high, after which 0x81 is received.
- Frame 0x55 with wr_rdy_i=0 → wr_err_o pulses once; no wr_o; data_o is unchanged.
- Frames 0x00 then 0xFF sent back-to-back, with ±3% baud skew → two wr_o pulses carrying 0x00 and 0xFF.
- rst_i asserted mid-data of 0x12, then frame 0x34 → all outputs 0 during reset; no pulses for 0x12; 0x34 is received.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 → line_err_o pulses and no wr_o. 0x07 with parity bit 1 → wr_o with data_o=0x07.

Source files
------------

// File: rtl/uart_rx_os_pkg.sv
// Shared UART parameters, receiver state encoding and bit-divider helper.
// Optional feature macro: UART_RX_PARITY_EN adds the PAR state (frame DATA_W,E,1).
package hive_params;

  localparam int UART_W       = 8;
  localparam int UART_BAUD_HZ = 115200;
  localparam int CORE_HZ      = 160000000;
  localparam int UART_RX_OSR  = 16;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PAR   = 3'd3,
`endif
    RX_STOP  = 3'd4,
    RX_BRK   = 3'd5
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest and never below one.
  function automatic int uart_div(input int clk_hz, input int baud_hz, input int osr);
    longint den;
    longint q;
    den = longint'(baud_hz) * longint'(osr);
    q   = (longint'(clk_hz) + den / 2) / den;
    return (q < 1) ? 1 : int'(q);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample timebase: integer clock divider feeding a 0..OSR-1 tick counter.
// A synchronous clear re-phases both counters to the start of a bit.
module uart_os_tick #(
  parameter int DIV = 1,
  parameter int OSR = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  output logic                   tick_o,
  output logic [$clog2(OSR)-1:0] tick_cnt_o,
  output logic                   bit_end_o
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW = $clog2(OSR);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] OSR_LAST = TW'(OSR - 1);

  logic [DW-1:0] r_div;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_div      <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_tick_cnt <= (r_tick_cnt == OSR_LAST) ? '0 : r_tick_cnt + 1'b1;
      end
    end
  end

  assign tick_o     = w_tick;
  assign tick_cnt_o = r_tick_cnt;
  assign bit_end_o  = w_tick && (r_tick_cnt == OSR_LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority voting and write-ready handshake.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data and stop).
//
// state    | meaning
// RX_IDLE  | line idle, timebase held cleared, waiting for rx_s low
// RX_START | start bit being qualified
// RX_DATA  | DATA_W data bits shifted in, LSB first
// RX_PAR   | parity bit checked (UART_RX_PARITY_EN only)
// RX_STOP  | stop bit decision, word delivered or dropped
// RX_BRK   | line held low after a framing error, wait for a full high tick
module uart_rx_os
  import hive_params::*;
#(
  parameter int DATA_W  = UART_W,
  parameter int SYNC_W  = 2,
  parameter int CLK_HZ  = CORE_HZ,
  parameter int BAUD_HZ = UART_BAUD_HZ,
  parameter int OSR     = UART_RX_OSR
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  input  logic              wr_rdy_i,
  output logic              wr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              line_err_o,
  output logic              wr_err_o
);

  localparam int DIV = uart_div(CLK_HZ, BAUD_HZ, OSR);
  localparam int TW  = $clog2(OSR);
  localparam int IW  = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] T_S0  = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OSR / 2);
  localparam logic [TW-1:0] T_DEC = TW'(OSR / 2 + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W);

  logic [SYNC_W-1:0] r_sync;
  logic              w_rx_s;

  rx_state_t r_state;
  rx_state_t w_state_nxt;

  logic          w_tick;
  logic          w_bit_end;
  logic          w_tick_clr;
  logic [TW-1:0] w_tick_cnt;

  logic r_smp0;
  logic r_smp1;
  logic w_maj;
  logic w_decide;

  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data;
  logic [IW-1:0]     r_bit_idx;

  logic r_wr;
  logic r_line_err;
  logic r_wr_err;
  logic w_wr_nxt;
  logic w_line_err_nxt;
  logic w_wr_err_nxt;
  logic w_shift_en;
  logic w_idx_clr;

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  logic w_par_set;
`endif

  // Preset to ones so reset looks like an idle line, not a start bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_W-2:0], rx_i};
    end
  end

  assign w_rx_s = r_sync[SYNC_W-1];

  // Timebase stays cleared while idle; in BRK any low sample restarts the tick.
  assign w_tick_clr = (r_state == RX_IDLE) || ((r_state == RX_BRK) && !w_rx_s);

  uart_os_tick #(
    .DIV (DIV),
    .OSR (OSR)
  ) u_tick (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (w_tick_clr),
    .tick_o     (w_tick),
    .tick_cnt_o (w_tick_cnt),
    .bit_end_o  (w_bit_end)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_smp0 <= 1'b0;
      r_smp1 <= 1'b0;
    end else if (w_tick) begin
      if (w_tick_cnt == T_S0) r_smp0 <= w_rx_s;
      if (w_tick_cnt == T_S1) r_smp1 <= w_rx_s;
    end
  end

  assign w_decide = w_tick && (w_tick_cnt == T_DEC);
  assign w_maj    = (r_smp0 & r_smp1) | (r_smp0 & w_rx_s) | (r_smp1 & w_rx_s);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_nxt       = 1'b0;
    w_line_err_nxt = 1'b0;
    w_wr_err_nxt   = 1'b0;
    w_shift_en     = 1'b0;
    w_idx_clr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_set      = 1'b0;
`endif
    case (r_state)
      RX_IDLE: begin
        if (!w_rx_s) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (w_decide) begin
          if (w_maj) begin
            w_line_err_nxt = 1'b1;
            w_state_nxt    = RX_IDLE;
          end else begin
            w_idx_clr   = 1'b1;
            w_state_nxt = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        w_shift_en = w_decide;
        // Leave at the end of the last data bit so the next decision lands in the next bit.
        if (w_bit_end && (r_bit_idx == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = RX_PAR;
`else
          w_state_nxt = RX_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PAR: begin
        if (w_decide) begin
          w_par_set   = (w_maj != (^r_shift));
          w_state_nxt = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (w_decide) begin
          w_state_nxt = RX_IDLE;
          if (!w_maj) begin
            w_line_err_nxt = 1'b1;
            w_state_nxt    = RX_BRK;
          end
`ifdef UART_RX_PARITY_EN
          else if (r_par_err) begin
            w_line_err_nxt = 1'b1;
          end
`endif
          else if (wr_rdy_i) begin
            w_wr_nxt = 1'b1;
          end else begin
            w_wr_err_nxt = 1'b1;
          end
        end
      end
      RX_BRK: begin
        if (w_tick && w_rx_s) w_state_nxt = RX_IDLE;
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_data     <= '0;
      r_wr       <= 1'b0;
      r_line_err <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_wr       <= w_wr_nxt;
      r_line_err <= w_line_err_nxt;
      r_wr_err   <= w_wr_err_nxt;
      if (w_wr_nxt) r_data <= r_shift;
      if (w_idx_clr) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_shift   <= {w_maj, r_shift[DATA_W-1:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_par_err <= 1'b0;
    end else if (w_idx_clr) begin
      r_par_err <= 1'b0;
    end else if (w_par_set) begin
      r_par_err <= 1'b1;
    end
  end
`endif

  assign wr_o       = r_wr;
  assign data_o     = r_data;
  assign line_err_o = r_line_err;
  assign wr_err_o   = r_wr_err;

endmodule
